// File: rtl/spi_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_slave: clk-sampled SPI slave bridging frames to a memory interface   |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module spi_slave #(
  parameter int   MEM_DEPTH = 256,
  localparam int  ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int CNT_W = $clog2(ADDR_SIZE + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ADDR_SIZE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_SIZE:0]    r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [ADDR_SIZE-1:0]  r_tx_shift;
  logic [CNT_W-1:0]      r_tx_cnt;
  logic                  r_rx_done;
  logic                  r_tx_active;
  logic                  r_tx_done;
  logic                  r_rd_addr_seen;
  logic                  r_miso;
  logic [ADDR_SIZE+1:0]  r_rx_data;
  logic                  r_rx_valid;

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (SS_n) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               w_next_state = WRITE;
          else if (r_rd_addr_seen) w_next_state = READ_DATA;
          else                     w_next_state = READ_ADD;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_rx_done      <= 1'b0;
      r_tx_active    <= 1'b0;
      r_tx_done      <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_miso         <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (SS_n) begin
        // Abort keeps rx_data and rd_addr_seen so a split read can resume.
        r_bit_cnt   <= '0;
        r_tx_cnt    <= '0;
        r_rx_done   <= 1'b0;
        r_tx_active <= 1'b0;
        r_tx_done   <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          CHK_CMD: begin
            r_shift   <= {r_shift[ADDR_SIZE-1:0], MOSI};
            r_bit_cnt <= '0;
            r_rx_done <= 1'b0;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!r_rx_done) begin
              r_shift <= {r_shift[ADDR_SIZE-1:0], MOSI};
              if (r_bit_cnt == C_LAST) begin
                r_rx_data  <= {r_shift, MOSI};
                r_rx_valid <= 1'b1;
                r_rx_done  <= 1'b1;
                if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else if (r_state == READ_DATA && !r_tx_done) begin
              if (!r_tx_active) begin
                if (tx_valid) begin
                  r_tx_shift  <= tx_data;
                  r_tx_active <= 1'b1;
                  r_tx_cnt    <= '0;
                end
              end else if (r_tx_cnt == C_LAST) begin
                r_miso         <= 1'b0;
                r_tx_active    <= 1'b0;
                r_tx_done      <= 1'b1;
                r_rd_addr_seen <= 1'b0;
              end else begin
                r_miso     <= r_tx_shift[ADDR_SIZE-1];
                r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
                r_tx_cnt   <= r_tx_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_spi_slave: directed self-checking bench for spi_slave                 |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  spi_slave #(.MEM_DEPTH(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge 0 samples SS_n low, edges 1..nbits sample the word bits MSB first.
  task automatic run_frame(input logic [9:0] w, input int nbits,
                           output int pulses, output logic last_v);
    pulses = 0;
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 10 - nbits; i--) begin
      MOSI = w[i];
      tick();
      if (rx_valid) pulses++;
    end
    last_v = rx_valid;
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
  endtask

  task automatic full_frame(input string tag, input logic [9:0] w);
    int   p;
    logic lv;
    run_frame(w, 10, p, lv);
    chk({tag, "_rxv_at_last_bit"}, 32'(lv), 32'd1);
    chk({tag, "_pulses"}, 32'(p), 32'd1);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(w));
  endtask

  // Presents tx_data for one cycle and returns the 8 MISO bits that follow.
  task automatic get_miso(input logic [7:0] d, output logic [7:0] v, output logic early);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    early = MISO;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      v = {v[6:0], MISO};
    end
  endtask

  task automatic miso_quiet(input string tag);
    logic any_one;
    any_one = 1'b0;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (MISO) any_one = 1'b1;
    end
    tx_valid = 1'b0;
    chk({tag, "_miso_quiet"}, 32'(any_one), 32'd0);
  endtask

  initial begin
    logic [7:0] bits;
    logic       early;
    int         p;
    logic       lv;

    #12;
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_miso", 32'(MISO), 32'd0);
    rst_n = 1'b1;
    tick();

    full_frame("wr_addr", 10'h03C);
    tick();
    chk("wr_addr_rxv_drop", 32'(rx_valid), 32'd0);
    chk("wr_addr_hold", 32'(rx_data), 32'h03C);
    end_frame();

    full_frame("wr_data", 10'h1A5);
    miso_quiet("wr_data");
    chk("wr_data_no_extra_pulse", 32'(rx_valid), 32'd0);
    end_frame();

    full_frame("rd_addr", 10'h23C);
    miso_quiet("rd_addr");
    end_frame();

    full_frame("rd_data", 10'h300);
    get_miso(8'hA5, bits, early);
    chk("rd_data_miso_before", 32'(early), 32'd0);
    chk("rd_data_miso_bits", 32'(bits), 32'hA5);
    tick();
    chk("rd_data_miso_after", 32'(MISO), 32'd0);
    miso_quiet("rd_data_done");
    end_frame();

    // rd_addr_seen was cleared, so a second 11 frame takes the READ_ADD path.
    full_frame("cmd_mismatch", 10'h300);
    miso_quiet("cmd_mismatch");
    end_frame();

    run_frame(10'h155, 5, p, lv);
    chk("abort_pulses", 32'(p), 32'd0);
    end_frame();
    chk("abort_rxv", 32'(rx_valid), 32'd0);
    chk("abort_rx_data_kept", 32'(rx_data), 32'h300);

    // rd_addr_seen survived the abort, so this frame returns data.
    full_frame("after_abort", 10'h300);
    get_miso(8'h5A, bits, early);
    chk("after_abort_miso_bits", 32'(bits), 32'h5A);
    end_frame();

    full_frame("rst_rd_addr", 10'h211);
    end_frame();
    full_frame("rst_rd_data", 10'h3FF);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("rst_miso_shifting", 32'(MISO), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_miso", 32'(MISO), 32'd0);
    chk("rst_async_rx_data", 32'(rx_data), 32'd0);
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    full_frame("post_rst", 10'h300);
    miso_quiet("post_rst");
    end_frame();
    full_frame("post_rst_rd", 10'h300);
    get_miso(8'hC3, bits, early);
    chk("post_rst_rd_miso_bits", 32'(bits), 32'hC3);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
